// File: rtl/booth_mul_vr_if.sv
// booth_mul_vr_if: source/destination handshake bundle for booth_mul_vr.
//   W             operand width; the product is 2*W bits
//   src_valid     operand pair valid              (producer -> multiplier)
//   src_ready     multiplier idle, can accept     (multiplier -> producer)
//   multiplicand  operand M, W bits
//   multiplier    operand Q, W bits
//   src_signed    1 = signed operands, 0 = unsigned (only with BOOTH_MUL_UNSIGNED_EN)
//   dest_valid    product valid                   (multiplier -> consumer)
//   dest_ready    consumer accepts the product    (consumer -> multiplier)
//   product       registered 2*W-bit result
// Modports: master = operand producer / result consumer side, slave = multiplier.
interface booth_mul_vr_if #(
  parameter int W = 16
);
  logic           src_valid;
  logic           src_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
`ifdef BOOTH_MUL_UNSIGNED_EN
  logic           src_signed;
`endif
  logic           dest_valid;
  logic           dest_ready;
  logic [2*W-1:0] product;

  modport master (
    output src_valid, multiplicand, multiplier,
`ifdef BOOTH_MUL_UNSIGNED_EN
    output src_signed,
`endif
    output dest_ready,
    input  src_ready, dest_valid, product
  );

  modport slave (
    input  src_valid, multiplicand, multiplier,
`ifdef BOOTH_MUL_UNSIGNED_EN
    input  src_signed,
`endif
    input  dest_ready,
    output src_ready, dest_valid, product
  );
endinterface

// File: rtl/booth_mul_vr.sv
// booth_mul_vr: radix-2 Booth sequential multiplier, one Booth step per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    booth_mul_vr_if.slave: src_valid/src_ready/multiplicand/multiplier
//          in, dest_valid/dest_ready/product out (see the interface header).
// Flow: IDLE accepts one operand pair, RUN performs N Booth steps, DONE holds
// the product until dest_ready. src_ready/dest_valid decode from state only.
// Optional feature macro BOOTH_MUL_UNSIGNED_EN: adds bus.src_signed; operands
// are extended to W+1 bits (sign or zero) so unsigned operands multiply
// correctly, and N becomes W+1. Default build: two's complement only, N = W.
// The interface instance must be built with the same W as this module.
module booth_mul_vr #(
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mul_vr_if.slave   bus
);

`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int EW = W + 1;   // operand width after sign/zero extension
`else
  localparam int EW = W;
`endif
  localparam int N  = EW;      // Booth iterations
  localparam int AW = EW + 1;  // guard bit keeps A - (-2^(EW-1)) in range
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  a;
  logic [EW-1:0]  q;
  logic [EW-1:0]  m;
  logic           q_1;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] product;

  logic           last_step;
  logic [EW-1:0]  m_ext, q_ext;
  logic [AW-1:0]  m_wide, a_sum, a_shr;
  logic [EW-1:0]  q_shr;

  assign last_step = (cnt == CW'(N - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.src_valid)  state_nxt = RUN;
      RUN:     if (last_step)      state_nxt = DONE;
      DONE:    if (bus.dest_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------- operand extension
`ifdef BOOTH_MUL_UNSIGNED_EN
  // Extra top bit: copy of the sign in signed mode, zero in unsigned mode.
  assign m_ext = {bus.src_signed & bus.multiplicand[W-1], bus.multiplicand};
  assign q_ext = {bus.src_signed & bus.multiplier[W-1],   bus.multiplier};
`else
  assign m_ext = bus.multiplicand;
  assign q_ext = bus.multiplier;
`endif

  // -------------------------------------------------------- Booth step
  assign m_wide = {m[EW-1], m};

  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b10:   a_sum = a - m_wide;
      2'b01:   a_sum = a + m_wide;
      default: a_sum = a;
    endcase
  end

  // Arithmetic right shift of {A,Q,Q_1}; the bit leaving Q becomes Q_1.
  assign a_shr = {a_sum[AW-1], a_sum[AW-1:1]};
  assign q_shr = {a_sum[0], q[EW-1:1]};

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a       <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.src_valid) begin
            m   <= m_ext;
            q   <= q_ext;
            a   <= '0;
            q_1 <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          a   <= a_shr;
          q   <= q_shr;
          q_1 <= q[0];
          cnt <= cnt + CW'(1);
          // Low 2W bits of the final {A,Q}; upper extension bits are redundant.
          if (last_step) product <= {a_shr[2*W-EW-1:0], q_shr};
        end
        default: ;
      endcase
    end
  end

  assign bus.src_ready  = (state == IDLE);
  assign bus.dest_valid = (state == DONE);
  assign bus.product    = product;

endmodule

// File: tb/tb_booth_mul_vr.sv
// tb_booth_mul_vr: randomized and directed bench for booth_mul_vr (W=8).
// A transaction-level model (integer multiply, idle/busy flag, due cycle)
// predicts src_ready, dest_valid and product on every falling edge.
module tb_booth_mul_vr;
  localparam int W = 8;
`ifdef BOOTH_MUL_UNSIGNED_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  booth_mul_vr_if #(.W(W)) bus ();
  booth_mul_vr #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, issued = 0, due = 0, last_acc = 0;
  int dr_mode = 1;   // 0: dest_ready low, 1: high, 2: random
  bit m_idle = 1'b1, have_last = 1'b0;
  logic [2*W-1:0] exp_p = '0, last_prod = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] mm, input logic [W-1:0] qq, input bit sg);
    longint a, b, p;
    a = longint'(mm);
    b = longint'(qq);
    if (sg && mm[W-1]) a -= (longint'(1) << W);
    if (sg && qq[W-1]) b -= (longint'(1) << W);
    p = a * b;
    return p[2*W-1:0];
  endfunction

  function automatic bit cur_sgn();
`ifdef BOOTH_MUL_UNSIGNED_EN
    return bus.src_signed;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every falling edge.
  always @(negedge clk) begin
    bit exp_dv;
    if (!rst_n) begin
      check("rst_src_ready", bus.src_ready, 1'b1);
      check("rst_dest_valid", bus.dest_valid, 1'b0);
      check("rst_product", bus.product, '0);
      m_idle    = 1'b1;
      have_last = 1'b0;
    end else begin
      exp_dv = !m_idle && (cyc >= due);
      check("src_ready", bus.src_ready, m_idle);
      check("dest_valid", bus.dest_valid, exp_dv);
      if (exp_dv) check("product", bus.product, exp_p);
      if (m_idle && bus.src_valid) begin
        exp_p = ref_mul(bus.multiplicand, bus.multiplier, cur_sgn());
        due   = cyc + 1 + N;
        if (have_last) check("period_min", (cyc - last_acc) >= N + 2, 1'b1);
        have_last = 1'b1;
        last_acc  = cyc;
        m_idle    = 1'b0;
        issued++;
      end else if (exp_dv && bus.dest_ready) begin
        last_prod = bus.product;
        m_idle    = 1'b1;
        done_cnt++;
      end
    end
  end

  // Consumer side.
  initial begin
    bus.dest_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (dr_mode)
        0:       bus.dest_ready = 1'b0;
        1:       bus.dest_ready = 1'b1;
        default: bus.dest_ready = ($urandom % 3) != 0;
      endcase
    end
  end

  // All driver tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] mm, input logic [W-1:0] qq, input bit sg);
    int k = 0;
    while (bus.src_ready !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got src_ready %0b expected 1", bus.src_ready);
    end
    bus.src_valid    = 1'b1;
    bus.multiplicand = mm;
    bus.multiplier   = qq;
`ifdef BOOTH_MUL_UNSIGNED_EN
    bus.src_signed   = sg;
`else
    if (!sg) $display("note: unsigned request ignored in signed-only build");
`endif
    @(posedge clk); #1;
    bus.src_valid    = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 400) begin
      @(posedge clk); #1; k++;
    end
    if (done_cnt < target) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got %0d results expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    int base, base_iss, k;
    bit sg;
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_iss, k;
    bit sg;
    bus.src_valid    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
`ifdef BOOTH_MUL_UNSIGNED_EN
    bus.src_signed   = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed products.
    check("model_7x-3", ref_mul(8'd7, 8'hFD, 1'b1), 16'hFFEB);
    check("model_-128x-128", ref_mul(8'h80, 8'h80, 1'b1), 16'h4000);
    check("model_-128x127", ref_mul(8'h80, 8'h7F, 1'b1), 16'hC080);
    check("model_u255x255", ref_mul(8'hFF, 8'hFF, 1'b0), 16'hFE01);

    // Basic signed products, consumer always ready.
    dr_mode = 1;
    send(8'd7, 8'hFD, 1'b1);   wait_done(1); check("t_7x-3", last_prod, 16'hFFEB);
    send(8'h80, 8'h80, 1'b1);  wait_done(2); check("t_-128x-128", last_prod, 16'h4000);
    send(8'h80, 8'h7F, 1'b1);  wait_done(3); check("t_-128x127", last_prod, 16'hC080);

    // Consumer stall with stray src_valid pulses during RUN and DONE.
    dr_mode = 0;
    base = done_cnt;
    send(8'd5, 8'd9, 1'b1);
    k = 0;
    while (bus.dest_valid !== 1'b1 && k < 40) begin
      bus.src_valid = $urandom_range(1, 0);
      @(posedge clk); #1; k++;
    end
    for (int i = 0; i < 6; i++) begin
      check("hold_product", bus.product, 16'h002D);
      check("hold_dest_valid", bus.dest_valid, 1'b1);
      bus.src_valid = $urandom_range(1, 0);
      @(posedge clk); #1;
    end
    bus.src_valid = 1'b0;
    dr_mode = 1;
    wait_done(base + 1);
    repeat (3) begin @(posedge clk); #1; end
    check("single_handshake", done_cnt - base, 1);

    // Reset during RUN, step 4: asynchronous clear, no result.
    base = done_cnt;
    send(8'h21, 8'h35, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_src_ready", bus.src_ready, 1'b1);
    check("async_dest_valid", bus.dest_valid, 1'b0);
    check("async_product", bus.product, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd3, 8'd4, 1'b1);
    wait_done(base + 1);
    check("post_reset_3x4", last_prod, 16'h000C);
    repeat (3) begin @(posedge clk); #1; end
    check("discarded_txn", done_cnt - base, 1);

    // Randomized back-to-back traffic with random stalls.
    dr_mode  = 2;
    base     = done_cnt;
    base_iss = issued;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
`ifdef BOOTH_MUL_UNSIGNED_EN
      sg = $urandom_range(1, 0);
`else
      sg = 1'b1;
`endif
      send(W'($urandom), W'($urandom), sg);
    end
    wait_done(base + 200);
    check("rand_done_count", done_cnt - base, 200);
    check("rand_issued_count", issued - base_iss, 200);
    dr_mode = 1;

`ifdef BOOTH_MUL_UNSIGNED_EN
    base = done_cnt;
    send(8'hFF, 8'hFF, 1'b0); wait_done(base + 1); check("u255x255", last_prod, 16'hFE01);
    send(8'hFF, 8'hFF, 1'b1); wait_done(base + 2); check("s-1x-1", last_prod, 16'h0001);
`endif

    repeat (2) begin @(posedge clk); #1; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
